uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver for the monitor FPGA. It runs entirely in the `clk50` domain, using an internal oversampling tick instead of a derived baud clock. Frame format is set by parameters: data width, parity mode and stop-bit count. Received bytes are presented on a valid/ready handshake with per-frame error flags, and `rts` provides hardware flow control.

## Interface
- `CLK_FRQ`, 50_000_000: source clock frequency in Hz.
- `BAUD_RATE`, 115200: line bit rate.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 8.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 2: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk50`  in  1: system clock. One clock; reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high.
- `rx`  in  1: asynchronous serial line; idle high.
- `rx_enable`  in  1: receiver enable.
- `data`  out  DATA_BITS: received word, LSB = first bit on the line.
- `valid`  out  1: `data` and the error flags are valid.
- `ready`  in  1: consumer accepts the word when `valid && ready`.
- `parity_err`  out  1: parity mismatch on the held word.
- `frame_err`  out  1: a stop bit sampled low on the held word.
- `overrun`  out  1: sticky flag; a frame completed while `valid` was high.
- `err_clr`  in  1: clears `overrun`.
- `busy`  out  1: state is not IDLE.
- `rts`  out  1: `rx_enable && !valid` (high = peer may send).

## Operation
- **Tick generator**
  - Divisor DIV = (CLK_FRQ + BAUD_RATE·OVERSAMPLE/2) / (BAUD_RATE·OVERSAMPLE), i.e. rounded; 27 at the defaults.
  - `tick` is a one-cycle pulse every DIV clocks, free-running from reset.
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- **State machine**
  - IDLE: on a tick with `rx_enable` high and synced rx = 0, go to START and clear the tick counter.
  - START: on the (OVERSAMPLE/2)th tick after detection, a high sample is a false start → IDLE with no output. A low sample → DATA.
  - DATA: sample every OVERSAMPLE ticks and shift LSB-first. After DATA_BITS samples, go to PARITY (PARITY≠0) or STOP.
  - PARITY: one sample, compared against XOR of data (even) or its inverse (odd).
  - STOP: STOP_BITS samples; any low sample sets the frame's frame_err. After the last sample, deliver the frame → IDLE (the next start bit can be detected half a bit early).
- **Delivery**
  - If `valid` = 0: load `data`, `parity_err`, `frame_err`; set `valid`.
  - If `valid` = 1: the new frame is discarded, the held word is unchanged, and `overrun` is set.
- **Handshake:** `valid && ready` clears `valid`, `parity_err` and `frame_err` at the next edge. Delivery and handshake in the same cycle: the handshake takes effect first, so the new frame loads and no overrun occurs.
- **Disable:** deasserting `rx_enable` mid-frame aborts to IDLE on the next clock. No delivery occurs, and the held word is kept.
- **Flag clear:** `err_clr` clears `overrun`. If a set condition occurs in the same cycle, set wins.
- **Reset (including mid-frame):**
  - State IDLE; `data` = 0; `valid`, `parity_err`, `frame_err`, `overrun`, `busy` = 0.
  - Tick counter = 0; synchroniser = 1.
  - `rts` = 0 while `rx_enable` = 0.

## Timing
- Ticks are counted from the detecting tick, which is tick 0.
- With N = DATA_BITS + (PARITY≠0) + STOP_BITS, the last sample is at tick OVERSAMPLE/2 + OVERSAMPLE·N.
- `valid` rises one clk50 cycle after that tick.
  - 8N1 at OVERSAMPLE = 16: tick 152.
  - 8E1: tick 168.
- `rts` is combinational from registered `valid` and `rx_enable`.
- `busy` is registered and rises in the cycle after the detecting tick.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:**
  - Each bit (start check, data, parity, stop) is the 2-of-3 majority of the samples at ticks mid−1, mid and mid+1.
  - The decision is taken at mid+1, so every sample point and `valid` move one tick later (8N1: tick 153).
- **Not defined:** single sample at the mid tick, with latencies as stated under Timing.

## Test plan
- **8N1, basic frame:** send 0xA5 with `ready` = 1 → `valid` for one cycle, starting one cycle after tick 152; `data` = 0xA5; no error flags.
- **Parity error:** PARITY = 2, send 0x3C with the parity bit = 1 → `data` = 0x3C, `parity_err` = 1. The next correct frame → `parity_err` = 0.
- **Framing error:** send 0x55 with the stop bit held low → `frame_err` = 1. Then hold rx high → the next frame is received cleanly.
- **False start:** a 3-tick low glitch, then high → no `valid`; `busy` returns to 0 by tick 8.
- **Overrun:** `ready` = 0, send 0x11 then 0x22 → `data` stays 0x11 and `overrun` = 1. `err_clr` → `overrun` = 0. While `valid` = 1, `rts` = 0.
- **Abort and majority vote:**
  - Drop `rx_enable` during data bit 3 → IDLE, no `valid`.
  - With `UART_RX_MAJORITY_EN`, a single-tick glitch at a mid sample → the bit is still decoded correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Received-word handshake between uart_rx_param (master) and its consumer (slave).
// The receiver drives the word and its error flags; the consumer drives ready.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 parity_err;
   logic                 frame_err;

   modport master (
      output data,
      output valid,
      output parity_err,
      output frame_err,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  parity_err,
      input  frame_err,
      output ready
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready word output and RTS flow control.
// Optional UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote of ticks mid-1, mid, mid+1.
module uart_rx_param #(
   parameter int CLK_FRQ    = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 2,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk50,
   input  logic            reset,
   input  logic            rx,
   input  logic            rx_enable,
   uart_rx_param_if.master rx_if,
   output logic            overrun,
   input  logic            err_clr,
   output logic            busy,
   output logic            rts
);

   localparam int DIV   = (CLK_FRQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PH_W  = $clog2(OVERSAMPLE + 1);
   localparam int BC_W  = 4;
`ifdef UART_RX_MAJORITY_EN
   localparam int VOTE_DLY = 1;
`else
   localparam int VOTE_DLY = 0;
`endif
   localparam logic [PH_W-1:0] START_M = PH_W'(OVERSAMPLE / 2 + VOTE_DLY);
   localparam logic [PH_W-1:0] BIT_M   = PH_W'(OVERSAMPLE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic parity_ref(input logic [DATA_BITS-1:0] d, input logic odd);
      return odd ? ~(^d) : (^d);
   endfunction

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic [1:0]           sync_q, sync_d;
   logic [PH_W-1:0]      ph_q, ph_d;
   logic [BC_W-1:0]      bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 pbit_q, pbit_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 busy_q, busy_d;
`ifdef UART_RX_MAJORITY_EN
   logic                 vote0_q, vote0_d;
   logic                 vote1_q, vote1_d;
`endif

   logic                 tick_s, rx_s, hit_s, sample_s, handshake_s;
   logic                 deliver_s, overrun_set_s;
   logic                 parity_err_now_s, frame_err_now_s;
   logic [PH_W-1:0]      ph_nxt_s, target_s;

   assign tick_s      = (div_cnt_q == DIV_W'(DIV - 1));
   assign rx_s        = sync_q[1];
   assign ph_nxt_s    = ph_q + PH_W'(1);
   assign target_s    = (state_q == S_START) ? START_M : BIT_M;
   assign hit_s       = tick_s && (ph_nxt_s == target_s);
   assign handshake_s = valid_q && rx_if.ready;
`ifdef UART_RX_MAJORITY_EN
   assign sample_s = (vote0_q & vote1_q) | (vote0_q & rx_s) | (vote1_q & rx_s);
`else
   assign sample_s = rx_s;
`endif
   assign parity_err_now_s = (PARITY == 0) ? 1'b0 : (pbit_q != parity_ref(shift_q, PARITY == 1));
   assign frame_err_now_s  = ferr_acc_q | ~sample_s;

   // Next-state logic for tick divider, synchroniser, frame FSM and output registers.
   always_comb begin
      div_cnt_d     = tick_s ? {DIV_W{1'b0}} : div_cnt_q + DIV_W'(1);
      sync_d        = {sync_q[0], rx};
      state_d       = state_q;
      ph_d          = ph_q;
      bcnt_d        = bcnt_q;
      shift_d       = shift_q;
      pbit_d        = pbit_q;
      ferr_acc_d    = ferr_acc_q;
      data_d        = data_q;
      valid_d       = valid_q;
      parity_err_d  = parity_err_q;
      frame_err_d   = frame_err_q;
      overrun_d     = overrun_q;
      deliver_s     = 1'b0;
      overrun_set_s = 1'b0;
`ifdef UART_RX_MAJORITY_EN
      if (tick_s && (ph_nxt_s == target_s - PH_W'(2))) begin
         vote0_d = rx_s;
      end else begin
         vote0_d = vote0_q;
      end
      if (tick_s && (ph_nxt_s == target_s - PH_W'(1))) begin
         vote1_d = rx_s;
      end else begin
         vote1_d = vote1_q;
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (rx_enable && tick_s && !rx_s) begin
               state_d    = S_START;
               ph_d       = {PH_W{1'b0}};
               bcnt_d     = {BC_W{1'b0}};
               ferr_acc_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            if (!rx_enable) begin
               state_d = S_IDLE;
            end else if (tick_s) begin
               // Phase restarts at every decision so later bits stay centred on it.
               ph_d = hit_s ? {PH_W{1'b0}} : ph_nxt_s;
               if (hit_s) begin
                  case (state_q)
                     S_START: begin
                        state_d = sample_s ? S_IDLE : S_DATA;
                     end
                     S_DATA: begin
                        shift_d = {sample_s, shift_q[DATA_BITS-1:1]};
                        if (bcnt_q == BC_W'(DATA_BITS - 1)) begin
                           bcnt_d  = {BC_W{1'b0}};
                           state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                           bcnt_d = bcnt_q + BC_W'(1);
                        end
                     end
                     S_PARITY: begin
                        pbit_d  = sample_s;
                        state_d = S_STOP;
                     end
                     S_STOP: begin
                        ferr_acc_d = frame_err_now_s;
                        if (bcnt_q == BC_W'(STOP_BITS - 1)) begin
                           deliver_s = 1'b1;
                           state_d   = S_IDLE;
                        end else begin
                           bcnt_d = bcnt_q + BC_W'(1);
                        end
                     end
                     default: begin
                        state_d = S_IDLE;
                     end
                  endcase
               end else begin
                  state_d = state_q;
               end
            end else begin
               state_d = state_q;
            end
         end
      endcase

      // Handshake is applied first so a same-cycle delivery lands in the freed slot.
      if (handshake_s) begin
         valid_d      = 1'b0;
         parity_err_d = 1'b0;
         frame_err_d  = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      if (deliver_s && (!valid_q || handshake_s)) begin
         data_d       = shift_q;
         valid_d      = 1'b1;
         parity_err_d = parity_err_now_s;
         frame_err_d  = frame_err_now_s;
      end else if (deliver_s) begin
         overrun_set_s = 1'b1;
      end else begin
         overrun_set_s = 1'b0;
      end
      if (overrun_set_s) begin
         overrun_d = 1'b1;
      end else if (err_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         div_cnt_q    <= {DIV_W{1'b0}};
         sync_q       <= 2'b11;
         ph_q         <= {PH_W{1'b0}};
         bcnt_q       <= {BC_W{1'b0}};
         shift_q      <= {DATA_BITS{1'b0}};
         pbit_q       <= 1'b0;
         ferr_acc_q   <= 1'b0;
         data_q       <= {DATA_BITS{1'b0}};
         valid_q      <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         vote0_q      <= 1'b1;
         vote1_q      <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         sync_q       <= sync_d;
         ph_q         <= ph_d;
         bcnt_q       <= bcnt_d;
         shift_q      <= shift_d;
         pbit_q       <= pbit_d;
         ferr_acc_q   <= ferr_acc_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
`ifdef UART_RX_MAJORITY_EN
         vote0_q      <= vote0_d;
         vote1_q      <= vote1_d;
`endif
      end
   end

   assign rx_if.data       = data_q;
   assign rx_if.valid      = valid_q;
   assign rx_if.parity_err = parity_err_q;
   assign rx_if.frame_err  = frame_err_q;
   assign overrun          = overrun_q;
   assign busy             = busy_q;
   assign rts              = rx_enable && !valid_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param in 8E1: frames are built bit by bit on the line,
// expected words come from the frame rules and are checked by an independent monitor.
module tb_uart_rx_param;

   localparam int CLK_FRQ = 1_000_000;
   localparam int BAUD    = 15_625;
   localparam int OS      = 16;
   localparam int DB      = 8;
   localparam int PAR     = 2;
   localparam int SB      = 1;
   localparam int DIV     = (CLK_FRQ + BAUD * OS / 2) / (BAUD * OS);
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   localparam int NBITS     = DB + 1 + SB;
   localparam int LAST_TICK = OS / 2 + OS * NBITS + MAJ;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         rise;
   } item_t;

   logic clk50, reset, rx, rx_enable, err_clr;
   logic overrun, busy, rts;
   int   cyc;
   int   tests, fails;
   item_t sb_q[$];

   uart_rx_param_if #(.DATA_BITS(DB)) rif ();

   uart_rx_param #(
      .CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
      .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)
   ) dut (
      .clk50(clk50), .reset(reset), .rx(rx), .rx_enable(rx_enable),
      .rx_if(rif), .overrun(overrun), .err_clr(err_clr), .busy(busy), .rts(rts)
   );

   initial begin
      clk50 = 1'b0;
      forever #5 clk50 = ~clk50;
   end

   // clk50 edges since reset release; ticks fall on edges where cyc is a multiple of DIV
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk50);
         if (reset) cyc = 0;
         else       cyc = cyc + 1;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do begin
            @(posedge clk50);
            #1;
         end while (cyc % DIV != 0);
      end
   endtask

   // Caller must be just after a tick edge; detection then happens on the next tick.
   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                             input int glitch_bit, input bit push, input bit chk_rise);
      logic [NBITS:0] bits;
      logic           pbit;
      item_t          it;
      pbit    = (^d) ^ bad_par;
      bits    = {~bad_stop, pbit, d, 1'b0};
      it.d    = d;
      it.pe   = ^{d, pbit};
      it.fe   = bad_stop;
      it.rise = chk_rise ? cyc + DIV * (1 + LAST_TICK) : 0;
      if (push) sb_q.push_back(it);
      for (int i = 0; i <= NBITS; i++) begin
         rx = bits[i];
         if (i == glitch_bit) begin
            wait_ticks(OS / 2);
            rx = ~bits[i];
            wait_ticks(1);
            rx = bits[i];
            wait_ticks(OS / 2 - 1);
         end else begin
            wait_ticks(OS);
         end
      end
      rx = 1'b1;
      wait_ticks(24 + int'($urandom_range(0, 8)));
   endtask

   // Monitor: pops one expected word per accepted handshake
   initial begin
      item_t it;
      logic  pv;
      int    rise;
      pv   = 1'b0;
      rise = 0;
      forever begin
         @(negedge clk50);
         if (reset) begin
            pv = 1'b0;
         end else begin
            if (rif.valid && !pv) rise = cyc;
            pv = rif.valid;
            if (rif.valid && rif.ready) begin
               if (sb_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_valid: got data %0h, expected no word", rif.data);
               end else begin
                  it = sb_q.pop_front();
                  check("data", 32'(rif.data), 32'(it.d));
                  check("parity_err", 32'(rif.parity_err), 32'(it.pe));
                  check("frame_err", 32'(rif.frame_err), 32'(it.fe));
                  if (it.rise != 0) check("valid_latency", rise, it.rise);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] ab;
      int         tgt;
      tests = 0; fails = 0;
      reset = 1'b1; rx = 1'b1; rx_enable = 1'b0; err_clr = 1'b0; rif.ready = 1'b1;
      repeat (4) @(posedge clk50);
      #1 reset = 1'b0;

      check("rst_data", 32'(rif.data), 32'h0);
      check("rst_valid", 32'(rif.valid), 32'h0);
      check("rst_perr", 32'(rif.parity_err), 32'h0);
      check("rst_ferr", 32'(rif.frame_err), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rts", 32'(rts), 32'h0);
      rx_enable = 1'b1;
      #1 check("rts_enabled", 32'(rts), 32'h1);
      wait_ticks(2);

      send_frame(8'hA5, 1'b0, 1'b0, -1, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b0, -1, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b1, 1'b1);
      send_frame(8'h55, 1'b0, 1'b1, -1, 1'b1, 1'b1);
      send_frame(8'h55, 1'b0, 1'b0, -1, 1'b1, 1'b1);

      // false start: three ticks low, then line idle
      rx = 1'b0;
      wait_ticks(3);
      rx = 1'b1;
      wait_ticks(2);
      check("false_start_busy", 32'(busy), 32'h1);
      wait_ticks(5);
      check("false_start_idle", 32'(busy), 32'h0);
      wait_ticks(20);

      for (int n = 0; n < 10; n++) begin
         send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    -1, 1'b1, 1'b1);
      end

      // overrun with consumer stalled
      rif.ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, -1, 1'b1, 1'b1);
      check("held_valid", 32'(rif.valid), 32'h1);
      check("held_rts", 32'(rts), 32'h0);
      send_frame(8'h22, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      check("overrun_data", 32'(rif.data), 32'h11);
      check("overrun_set", 32'(overrun), 32'h1);
      err_clr = 1'b1;
      @(posedge clk50); #1;
      err_clr = 1'b0;
      check("overrun_clr", 32'(overrun), 32'h0);
      rif.ready = 1'b1;
      @(posedge clk50); #1;
      rif.ready = 1'b0;
      wait_ticks(1);

      // handshake in the same cycle as the next delivery
      send_frame(8'h33, 1'b0, 1'b0, -1, 1'b1, 1'b1);
      tgt = cyc + DIV * (1 + LAST_TICK);
      fork
         send_frame(8'h44, 1'b0, 1'b0, -1, 1'b1, 1'b0);
         begin
            while (cyc < tgt - 1) begin
               @(posedge clk50); #1;
            end
            rif.ready = 1'b1;
            @(posedge clk50); #1;
            rif.ready = 1'b0;
         end
      join
      check("same_cycle_overrun", 32'(overrun), 32'h0);
      check("same_cycle_data", 32'(rif.data), 32'h44);
      rif.ready = 1'b1;
      wait_ticks(1);

      // abort during data bit 3
      ab = 8'h96;
      rx = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 3; i++) begin
         rx = ab[i];
         wait_ticks(OS);
      end
      rx = ab[3];
      wait_ticks(OS / 2);
      rx_enable = 1'b0;
      @(posedge clk50); #1;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_rts", 32'(rts), 32'h0);
      rx = 1'b1;
      wait_ticks(30);
      rx_enable = 1'b1;
      wait_ticks(1);

      // reset mid-frame while a word is held
      rif.ready = 1'b0;
      send_frame(8'h6B, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      rx = 1'b0;
      wait_ticks(OS);
      rx = 1'b1;
      wait_ticks(OS / 2);
      reset = 1'b1;
      @(posedge clk50); #1;
      @(posedge clk50); #1;
      check("midrst_data", 32'(rif.data), 32'h0);
      check("midrst_valid", 32'(rif.valid), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      rif.ready = 1'b1;
      wait_ticks(30);
      send_frame(8'hC3, 1'b0, 1'b0, -1, 1'b1, 1'b1);

`ifdef UART_RX_MAJORITY_EN
      send_frame(8'h5A, 1'b0, 1'b0, 4, 1'b1, 1'b1);
      send_frame(8'hE7, 1'b0, 1'b0, 0, 1'b1, 1'b1);
`endif

      for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clk50);
      check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
